// File: rtl/udp_rx_parser.sv
// udp_rx_parser: Avalon-ST sink that parses 32-bit beats of an Ethernet/IPv4/UDP
// frame, filters on destination MAC, EtherType, IP version/IHL, IP protocol,
// destination IP and destination UDP port, and extracts the speed/ADC sensor
// words. It never backpressures; results appear the cycle after the eop beat.
// Optional macro UDP_RX_IP_CSUM_EN adds an IPv4 header checksum check.
// Ports: Clock_xCI/Reset_xSI (sync, active-high); Rx_* = ST sink (readyLatency 0);
//        Speed_Sensor_xDO/Adc_xDO = last accepted payload words;
//        Packet_Valid_xSO = 1-cycle accept pulse; Good/Drop_Count_xDO = saturating counters.
module udp_rx_parser #(
  parameter logic [47:0] LOCAL_MAC   = 48'h001C_2317_4ACB,
  parameter logic [31:0] LOCAL_IP    = 32'hC0A8_0102,
  parameter logic [15:0] UDP_PORT    = 16'd4660,
  parameter int          COUNT_WIDTH = 16
) (
  input  logic                   Clock_xCI,
  input  logic                   Reset_xSI,
  input  logic [31:0]            Rx_Data_xDI,
  input  logic                   Rx_Valid_xSI,
  output logic                   Rx_Ready_xSO,
  input  logic                   Rx_Sop_xSI,
  input  logic                   Rx_Eop_xSI,
  input  logic [1:0]             Rx_Empty_xDI,
  input  logic                   Rx_Error_xSI,
  output logic [15:0]            Speed_Sensor_xDO,
  output logic [15:0]            Adc_xDO,
  output logic                   Packet_Valid_xSO,
  output logic [COUNT_WIDTH-1:0] Good_Count_xDO,
  output logic [COUNT_WIDTH-1:0] Drop_Count_xDO
);

  typedef enum logic [2:0] {S_IDLE, S_HDR, S_PAY, S_DRAIN, S_COMMIT} state_t;

  state_t      state;
  logic [4:0]  word_cnt;     // index of the next beat within the frame, saturates at 17
  logic [15:0] pend_speed;
  logic [15:0] pend_adc;

  logic        beat, start, in_frame;
  logic [4:0]  w_cur;
  logic        field_bad, hdr_bad, csum_ok, good_cond;
  logic        good_ev, drop_ev;

  assign beat     = Rx_Valid_xSI & Rx_Ready_xSO;
  assign start    = beat & Rx_Sop_xSI;
  assign in_frame = (state == S_HDR) || (state == S_PAY) || (state == S_DRAIN);
  assign w_cur    = Rx_Sop_xSI ? 5'd0 : word_cnt;

  always_comb begin
    field_bad = 1'b0;
    case (w_cur)
      5'd0:    field_bad = (Rx_Data_xDI[15:0]  != LOCAL_MAC[47:32]);
      5'd1:    field_bad = (Rx_Data_xDI        != LOCAL_MAC[31:0]);
      5'd3:    field_bad = (Rx_Data_xDI[15:0]  != 16'h0800);
      5'd4:    field_bad = (Rx_Data_xDI[31:24] != 8'h45);
      5'd6:    field_bad = (Rx_Data_xDI[23:16] != 8'd17);
      5'd8:    field_bad = (Rx_Data_xDI        != LOCAL_IP);
      5'd9:    field_bad = (Rx_Data_xDI[15:0]  != UDP_PORT);
      default: field_bad = 1'b0;
    endcase
  end

  // Header checks only apply to the sop beat and to beats while still in HDR.
  assign hdr_bad = (start || (beat && state == S_HDR)) && field_bad;

`ifdef UDP_RX_IP_CSUM_EN
  logic [15:0] csum_acc;

  function automatic logic [15:0] ones_add(input logic [15:0] a, input logic [15:0] b);
    logic [16:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[15:0] + {15'd0, s[16]};
  endfunction

  always_ff @(posedge Clock_xCI) begin
    if (Reset_xSI || start) begin
      csum_acc <= 16'd0;
    end else if (beat && state == S_HDR && word_cnt >= 5'd4 && word_cnt <= 5'd8) begin
      csum_acc <= ones_add(ones_add(csum_acc, Rx_Data_xDI[31:16]), Rx_Data_xDI[15:0]);
    end
  end

  assign csum_ok = (csum_acc == 16'hFFFF);
`else
  assign csum_ok = 1'b1;
`endif

  // An eop at W16 with empty bytes means the 24-byte payload is short.
  assign good_cond = (state == S_PAY) && (word_cnt >= 5'd16) && !Rx_Error_xSI &&
                     !((word_cnt == 5'd16) && (Rx_Empty_xDI != 2'd0)) && csum_ok;

  // A sop always ends the current frame (as a drop) and a sop+eop beat is a
  // runt, so good and drop can never fire together.
  assign good_ev = beat && Rx_Eop_xSI && !start && in_frame && good_cond;
  assign drop_ev = (start && in_frame) || (start && Rx_Eop_xSI) ||
                   (beat && Rx_Eop_xSI && !start && in_frame && !good_cond);

  always_ff @(posedge Clock_xCI) begin
    if (Reset_xSI) begin
      state            <= S_IDLE;
      word_cnt         <= 5'd0;
      pend_speed       <= 16'd0;
      pend_adc         <= 16'd0;
      Rx_Ready_xSO     <= 1'b0;
      Speed_Sensor_xDO <= 16'd0;
      Adc_xDO          <= 16'd0;
      Packet_Valid_xSO <= 1'b0;
      Good_Count_xDO   <= '0;
      Drop_Count_xDO   <= '0;
    end else begin
      Rx_Ready_xSO     <= 1'b1;
      Packet_Valid_xSO <= good_ev;

      if (good_ev) begin
        Speed_Sensor_xDO <= pend_speed;
        Adc_xDO          <= pend_adc;
        if (Good_Count_xDO != '1) Good_Count_xDO <= Good_Count_xDO + 1'b1;
      end
      if (drop_ev && Drop_Count_xDO != '1) Drop_Count_xDO <= Drop_Count_xDO + 1'b1;

      if (beat && state == S_PAY && !start && word_cnt == 5'd11) begin
        pend_speed <= Rx_Data_xDI[31:16];
        pend_adc   <= Rx_Data_xDI[15:0];
      end

      if (start) begin
        word_cnt <= 5'd1;
        if (Rx_Eop_xSI)   state <= S_COMMIT;
        else if (hdr_bad) state <= S_DRAIN;
        else              state <= S_HDR;
      end else if (beat && in_frame) begin
        if (word_cnt != 5'd17) word_cnt <= word_cnt + 5'd1;
        if (Rx_Eop_xSI) begin
          state <= S_COMMIT;
        end else if (state == S_HDR) begin
          if (hdr_bad)                state <= S_DRAIN;
          else if (word_cnt == 5'd10) state <= S_PAY;
        end
      end else if (state == S_COMMIT) begin
        // Non-sop beats arriving here belong to no frame and are discarded.
        state <= S_IDLE;
      end
    end
  end

endmodule
